cpu_clk_gate: RTL

//  Consumes the slow divided clock from the clock-divider stage and turns it into a
//  one-cycle clock-enable (cpu_ce) for the 8080 core, running on the fast system clk.

---
 rtl/cpu_clk_gate.sv | 120 ++++++++++++
 1 files changed

// File: rtl/cpu_clk_gate.sv
// rtl/cpu_clk_gate.sv - turns the divided clock into a one-cycle CPU clock-enable with RUN/STOP/STEP control
module cpu_clk_gate #(
    parameter int SYNC_STAGES = 2,
    parameter int STEP_MAX    = 64,
    parameter int STEP_W      = 7,
    parameter int CNT_W       = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             tick_in,
    input  logic             run_req,
    input  logic             stop_req,
    input  logic             step_req,
    input  logic             cpu_sync,
    input  logic             cpu_halt,
    output logic             cpu_ce,
    output logic             running,
    output logic             stepping,
    output logic             halted,
    output logic             step_timeout,
    output logic [CNT_W-1:0] ce_count
);

    typedef enum logic [1:0] {
        ST_STOP = 2'd0,
        ST_RUN  = 2'd1,
        ST_STEP = 2'd2
    } state_t;

    localparam logic [STEP_W-1:0] STEP_LAST = STEP_W'(STEP_MAX - 1);

    state_t                 state_q;
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   prev_q;
    logic                   cpu_ce_q;
    logic                   halted_q;
    logic                   timeout_q;
    logic [STEP_W-1:0]      step_cnt_q;
    logic [CNT_W-1:0]       ce_count_q;

    logic tick_rise;
    logic cpu_ce_d;

    assign tick_rise = sync_q[SYNC_STAGES-1] & ~prev_q;
    // Gate uses the pre-transition state, so a tick coinciding with stop_req still fires.
    assign cpu_ce_d  = tick_rise & (state_q == ST_RUN || state_q == ST_STEP);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= ST_STOP;
            sync_q     <= '0;
            prev_q     <= 1'b0;
            cpu_ce_q   <= 1'b0;
            halted_q   <= 1'b0;
            timeout_q  <= 1'b0;
            step_cnt_q <= '0;
            ce_count_q <= '0;
        end else begin
            sync_q   <= {sync_q[SYNC_STAGES-2:0], tick_in};
            prev_q   <= sync_q[SYNC_STAGES-1];
            cpu_ce_q <= cpu_ce_d;
            if (cpu_ce_q) begin
                ce_count_q <= ce_count_q + 1'b1;
            end

            case (state_q)
                ST_STOP: begin
                    if (stop_req) begin
                        state_q <= ST_STOP;
                    end else if (step_req) begin
                        state_q    <= ST_STEP;
                        halted_q   <= 1'b0;
                        timeout_q  <= 1'b0;
                        step_cnt_q <= '0;
                    end else if (run_req) begin
                        state_q   <= ST_RUN;
                        halted_q  <= 1'b0;
                        timeout_q <= 1'b0;
                    end
                end
                ST_RUN: begin
                    if (stop_req) begin
                        state_q <= ST_STOP;
                    end else if (cpu_halt) begin
                        state_q  <= ST_STOP;
                        halted_q <= 1'b1;
                    end
                end
                ST_STEP: begin
                    if (stop_req) begin
                        state_q <= ST_STOP;
                    end else if (cpu_halt) begin
                        state_q  <= ST_STOP;
                        halted_q <= 1'b1;
                    end else if (cpu_ce_q) begin
                        if (step_cnt_q != STEP_W'(STEP_MAX)) begin
                            step_cnt_q <= step_cnt_q + 1'b1;
                        end
                        // SYNC on a later ce means the next machine cycle has begun.
                        if (cpu_sync && step_cnt_q != '0) begin
                            state_q <= ST_STOP;
                        end else if (step_cnt_q >= STEP_LAST) begin
                            state_q   <= ST_STOP;
                            timeout_q <= 1'b1;
                        end
                    end
                end
                default: state_q <= ST_STOP;
            endcase
        end
    end

    assign cpu_ce       = cpu_ce_q;
    assign running      = (state_q == ST_RUN);
    assign stepping     = (state_q == ST_STEP);
    assign halted       = halted_q;
    assign step_timeout = timeout_q;
    assign ce_count     = ce_count_q;

endmodule
